topk_sequencer128: RTL and testbench

//  Drives and consumes the 128-lane pipelined max tree (maxtree128). Loads 128 candidate

---
 rtl/ms_pkg.sv | 36 +++
 rtl/ms_lane_bank.sv | 46 ++++
 rtl/topk_sequencer128.sv | 120 ++++++++++++
 tb/tb_topk_sequencer128.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ms_pkg.sv
// Shared definitions for the top-K sequencer: lane geometry, tree latency,
// FSM state encoding and the lane word layout {addr, indx, data}.
package ms_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int INDX_WIDTH = 10;
  localparam int ADDR_WIDTH = 7;
  localparam int LANES      = 1 << ADDR_WIDTH;
  localparam int TREE_LAT   = 8;
  localparam int LANE_W     = DATA_WIDTH + INDX_WIDTH + ADDR_WIDTH;
  localparam int WCNT_W     = (TREE_LAT > 1) ? $clog2(TREE_LAT) : 1;

  typedef enum logic [2:0] {FILL, ARM, WAIT, EMIT, DONE} state_t;

  // First member lands in the MSBs, so addr sits above indx above data.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [INDX_WIDTH-1:0] indx;
    logic [DATA_WIDTH-1:0] data;
  } lane_t;

  // Invalid lanes present an all-zero word to the tree.
  function automatic logic [LANE_W-1:0] pack_lane(input logic v,
                                                  input logic [ADDR_WIDTH-1:0] addr,
                                                  input logic [INDX_WIDTH-1:0] indx,
                                                  input logic [DATA_WIDTH-1:0] data);
    lane_t w;
    w.addr = addr;
    w.indx = indx;
    w.data = data;
    return v ? w : '0;
  endfunction

  function automatic lane_t unpack_lane(input logic [LANE_W-1:0] w);
    return lane_t'(w);
  endfunction
endpackage

// File: rtl/ms_lane_bank.sv
// Candidate lane storage: per-lane (valid, indx, data) registers.
// Ports: clk/rst; write port wr_en/wr_addr/wr_indx/wr_data (a zero score
// leaves the lane invalid); clr_en/clr_addr knocks one lane out; clr_all
// empties the bank; valid bitmap and flattened tree_din words out.
module ms_lane_bank
  import ms_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [INDX_WIDTH-1:0]   wr_indx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    clr_en,
  input  logic [ADDR_WIDTH-1:0]   clr_addr,
  input  logic                    clr_all,
  output logic [LANES-1:0]        valid,
  output logic [LANES*LANE_W-1:0] tree_din
);
  logic [INDX_WIDTH-1:0] indx_q [LANES];
  logic [DATA_WIDTH-1:0] data_q [LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (clr_all) begin
      valid <= '0;
    end else begin
      if (wr_en)  valid[wr_addr]  <= (wr_data != '0);
      if (clr_en) valid[clr_addr] <= 1'b0;
    end
  end

  // Payload needs no reset: the valid bit masks it off the tree.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      indx_q[wr_addr] <= wr_indx;
      data_q[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign tree_din[i*LANE_W +: LANE_W] =
      pack_lane(valid[i], ADDR_WIDTH'(i), indx_q[i], data_q[i]);
  end
endmodule

// File: rtl/topk_sequencer128.sv
// Top-K sequencer around an external 128-lane max tree. Fills the lane
// bank from the load stream, then loops ARM -> WAIT -> EMIT, knocking out
// each winner, until K winners are emitted or the bank runs dry.
// Ports: clk/rst; cfg_k; load_valid/ready/data/indx/last stream in;
// tree_start/tree_din to the tree, tree_max back; out_valid/ready/data/
// indx/addr/last winner stream; done end-of-run pulse.
// Widths are fixed by ms_pkg.
module topk_sequencer128
  import ms_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              cfg_k,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [DATA_WIDTH-1:0]   load_data,
  input  logic [INDX_WIDTH-1:0]   load_indx,
  input  logic                    load_last,
  output logic                    tree_start,
  output logic [LANES*LANE_W-1:0] tree_din,
  input  logic [LANE_W-1:0]       tree_max,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [INDX_WIDTH-1:0]   out_indx,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic                    out_last,
  output logic                    done
);
  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [7:0]            k_lat, cnt;
  logic [WCNT_W-1:0]     wait_cnt;
  logic [LANES-1:0]      valid;
  lane_t                 tm;
  logic                  ld_fire, fill_end, wait_exp, hit, out_hs, last_win, others_left;

  assign tm          = unpack_lane(tree_max);
  assign load_ready  = (state == FILL);
  assign ld_fire     = load_valid && load_ready;
  assign fill_end    = ld_fire && (load_last || ptr == ADDR_WIDTH'(LANES-1));
  assign wait_exp    = (state == WAIT) && (wait_cnt == WCNT_W'(TREE_LAT-1));
  // A zero score or a lane already knocked out means nothing is left.
  assign hit         = (tm.data != '0) && valid[tm.addr];
  assign out_hs      = (state == EMIT) && out_ready;
  assign last_win    = (cnt + 8'd1) == k_lat;
  // Anything left besides the lane being emitted? Saves a dead tree pass.
  assign others_left = |(valid & ~({{(LANES-1){1'b0}}, 1'b1} << out_addr));

  assign tree_start = (state == ARM);
  assign out_valid  = (state == EMIT);
  assign out_last   = out_valid && last_win;
  assign done       = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (fill_end) state_nxt = ARM;
      ARM:     state_nxt = WAIT;
      WAIT:    if (wait_exp) state_nxt = hit ? EMIT : DONE;
      EMIT:    if (out_ready) state_nxt = (last_win || !others_left) ? DONE : ARM;
      DONE:    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      k_lat    <= 8'd128;
      cnt      <= '0;
      wait_cnt <= '0;
      out_data <= '0;
      out_indx <= '0;
      out_addr <= '0;
    end else begin
      case (state)
        FILL: begin
          cnt <= '0;
          if (ld_fire) ptr <= ptr + 1'b1;
          if (fill_end) k_lat <= (cfg_k == 8'd0 || cfg_k > 8'd128) ? 8'd128 : cfg_k;
        end
        ARM:  wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_exp && hit) begin
            out_data <= tm.data;
            out_indx <= tm.indx;
            out_addr <= tm.addr;
          end
        end
        EMIT: if (out_ready) cnt <= cnt + 8'd1;
        DONE: begin
          ptr <= '0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  ms_lane_bank u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (ld_fire),
    .wr_addr  (ptr),
    .wr_indx  (load_indx),
    .wr_data  (load_data),
    .clr_en   (out_hs),
    .clr_addr (out_addr),
    .clr_all  (state == DONE),
    .valid    (valid),
    .tree_din (tree_din)
  );
endmodule

// File: tb/tb_topk_sequencer128.sv
// Directed bench for topk_sequencer128 with a behavioural 8-stage max tree
// (compares score field, lowest lane wins ties) behind the tree_* ports.
module tb_topk_sequencer128;
  import ms_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [7:0]              cfg_k = '0;
  logic                    load_valid = 1'b0, load_ready, load_last = 1'b0;
  logic [DATA_WIDTH-1:0]   load_data = '0;
  logic [INDX_WIDTH-1:0]   load_indx = '0;
  logic                    tree_start;
  logic [LANES*LANE_W-1:0] tree_din;
  logic [LANE_W-1:0]       tree_max;
  logic                    out_valid, out_ready = 1'b0, out_last, done;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [INDX_WIDTH-1:0]   out_indx;
  logic [ADDR_WIDTH-1:0]   out_addr;

  always #5 clk = ~clk;

  topk_sequencer128 dut (
    .clk(clk), .rst(rst), .cfg_k(cfg_k),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_indx(load_indx), .load_last(load_last),
    .tree_start(tree_start), .tree_din(tree_din), .tree_max(tree_max),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_indx(out_indx), .out_addr(out_addr), .out_last(out_last), .done(done)
  );

  // Behavioural max tree
  function automatic logic [LANE_W-1:0] tree_ref(input logic [LANES*LANE_W-1:0] din);
    lane_t best, cur;
    best = '0;
    for (int i = 0; i < LANES; i++) begin
      cur = lane_t'(din[i*LANE_W +: LANE_W]);
      if (cur.data > best.data) best = cur;
    end
    return best;
  endfunction

  logic [LANE_W-1:0] tpipe [TREE_LAT];
  always @(posedge clk) begin
    tpipe[0] <= tree_ref(tree_din);
    for (int i = 1; i < TREE_LAT; i++) tpipe[i] <= tpipe[i-1];
  end
  assign tree_max = tpipe[TREE_LAT-1];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: data=i+1, indx=i+3; mode 1: lanes 0..9 zero score; mode 2: 0x0123/5
  task automatic load(input int n, input int mode, input bit last_flag);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = (mode == 2) ? 16'h0123 : (mode == 1 && i < 10) ? 16'd0 : 16'(i + 1);
      load_indx  = (mode == 2) ? 10'd5 : 10'(i + 3);
      load_last  = last_flag && (i == n - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  int           r_outs, r_starts, r_lasts, r_last_idx, r_done_gap, r_stable_err;
  int           r_low_hit, r_order_err, r_ready_err;
  bit           r_done;
  logic [127:0] r_cover;
  lane_t        r_first, r_final;

  task automatic collect(input int stall, input bit hold_load, input int budget);
    int    stall_cnt, hs_cyc;
    lane_t snap, cur;
    bit    snap_last;
    r_outs = 0; r_starts = 0; r_lasts = 0; r_last_idx = 0; r_done_gap = -1;
    r_stable_err = 0; r_low_hit = 0; r_order_err = 0; r_ready_err = 0;
    r_done = 0; r_cover = '0; r_first = '0; r_final = '0;
    stall_cnt = 0; hs_cyc = -100; snap = '0; snap_last = 0;
    if (hold_load) begin
      load_valid = 1'b1; load_data = 16'hFFFF; load_indx = 10'h3FF;
    end
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (hold_load && load_ready) r_ready_err++;
      if (tree_start) r_starts++;
      if (done) begin
        r_done = 1; r_done_gap = cyc - hs_cyc;
        load_valid = 1'b0; out_ready = 1'b0;
        break;
      end
      if (out_valid) begin
        cur.addr = out_addr; cur.indx = out_indx; cur.data = out_data;
        if (stall_cnt == 0) begin
          snap = cur; snap_last = out_last;
        end else if (cur != snap || out_last != snap_last) r_stable_err++;
        if (stall_cnt < stall) begin
          out_ready = 1'b0; stall_cnt++;
        end else begin
          out_ready = 1'b1; stall_cnt = 0; hs_cyc = cyc;
          r_outs++;
          r_cover[out_addr] = 1'b1;
          if (out_addr < 10) r_low_hit++;
          if (out_data != 16'(out_addr) + 16'd1) r_order_err++;
          if (out_last) begin r_lasts++; r_last_idx = r_outs; end
          if (r_outs == 1) r_first = cur;
          r_final = cur;
        end
      end else out_ready = 1'b0;
      tick();
    end
    load_valid = 1'b0; out_ready = 1'b0;
    tick();   // DONE -> FILL
  endtask

  initial begin
    bit seen;
    tick(); tick();
    chk("rst_load_ready", load_ready, 1);
    chk("rst_tree_start", tree_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_out_fields", {out_addr, out_indx, out_data}, 0);
    rst = 1'b0;
    tick();

    // 1: single lane, K=4
    cfg_k = 8'd4;
    load(1, 2, 1);
    collect(0, 0, 300);
    chk("s1_outs", r_outs, 1);
    chk("s1_word", r_first, {7'd0, 10'd5, 16'h0123});
    chk("s1_last", r_lasts, 0);
    chk("s1_done", r_done, 1);
    chk("s1_starts", r_starts, 1);
    chk("s1_refill_ready", load_ready, 1);

    // 2: full bank, K=0 -> 128
    cfg_k = 8'd0;
    load(128, 0, 0);
    collect(0, 0, 4000);
    chk("s2_outs", r_outs, 128);
    chk("s2_cover", r_cover, {128{1'b1}});
    chk("s2_first", r_first, {7'd127, 10'd130, 16'd128});
    chk("s2_order", r_order_err, 0);
    chk("s2_last_idx", r_last_idx, 128);
    chk("s2_lasts", r_lasts, 1);
    chk("s2_done_gap", r_done_gap, 1);
    chk("s2_starts", r_starts, 128);

    // 3: K=3 with 20-cycle stalls
    cfg_k = 8'd3;
    load(128, 0, 0);
    collect(20, 0, 1000);
    chk("s3_outs", r_outs, 3);
    chk("s3_stable", r_stable_err, 0);
    chk("s3_last_idx", r_last_idx, 3);
    chk("s3_starts", r_starts, 3);
    chk("s3_final_addr", r_final.addr, 125);
    chk("s3_done", r_done, 1);

    // 4: zero-score lanes 0..9
    cfg_k = 8'd128;
    load(128, 1, 0);
    collect(0, 0, 4000);
    chk("s4_outs", r_outs, 118);
    chk("s4_low_lanes", r_low_hit, 0);
    chk("s4_starts", r_starts, 118);
    chk("s4_done", r_done, 1);

    // 5: load_valid held through the run
    cfg_k = 8'd0;
    load(128, 0, 0);
    collect(0, 1, 4000);
    chk("s5_ready_low", r_ready_err, 0);
    chk("s5_outs", r_outs, 128);
    chk("s5_cover", r_cover, {128{1'b1}});
    chk("s5_order", r_order_err, 0);
    chk("s5_done", r_done, 1);

    // 6: reset in WAIT, then reset while out_valid
    cfg_k = 8'd0;
    load(128, 0, 0);
    chk("s6_armed", tree_start, 1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("s6a_load_ready", load_ready, 1);
    chk("s6a_quiet", {tree_start, out_valid, out_last, done}, 0);
    rst = 1'b0;
    tick();
    cfg_k = 8'd5;
    load(128, 0, 0);
    seen = 0;
    for (int w = 0; w < 100; w++) begin
      if (out_valid) begin seen = 1; break; end
      tick();
    end
    chk("s6_out_seen", seen, 1);
    rst = 1'b1;
    tick();
    chk("s6b_out_valid", out_valid, 0);
    chk("s6b_out_fields", {out_last, out_addr, out_indx, out_data}, 0);
    chk("s6b_load_ready", load_ready, 1);
    rst = 1'b0;
    tick();
    cfg_k = 8'd2;
    load(4, 0, 1);
    collect(0, 0, 300);
    chk("s6c_outs", r_outs, 2);
    chk("s6c_first", r_first, {7'd3, 10'd6, 16'd4});
    chk("s6c_final_addr", r_final.addr, 2);
    chk("s6c_last_idx", r_last_idx, 2);
    chk("s6c_done", r_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
